// File: rtl/mixer_scheduler_pkg.sv
// Shared stream types, scheduler states and the product slice helper for mixer_scheduler.
// Defining MIXER_SCHEDULER_ROUNDING_EN makes mixSlice round half up instead of flooring.
package mixer_scheduler_pkg;

    localparam int DATA_W      = 18;
    localparam int PROD_W      = 34;
    localparam int MIXER_SHIFT = 15;

    typedef struct packed {
        logic signed [DATA_W-1:0] Data;
        logic                     Valid;
    } DATA_STREAM;

    typedef struct packed {
        logic signed [DATA_W-1:0] I;
        logic signed [DATA_W-1:0] Q;
        logic                     Valid;
    } COMPLEX_STREAM;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_I = 2'd1,
        MUL_Q = 2'd2
    } MIXER_SCHED_STATE;

    // Keeps bits [32:15] of the product; the top bit is dropped, so the full-scale corner wraps.
    function automatic logic signed [DATA_W-1:0] mixSlice(input logic [PROD_W-1:0] product);
        logic [PROD_W-1:0] adjusted;
`ifdef MIXER_SCHEDULER_ROUNDING_EN
        adjusted = product + (PROD_W'(1) << (MIXER_SHIFT - 1));
`else
        adjusted = product;
`endif
        return adjusted[MIXER_SHIFT +: DATA_W];
    endfunction

endpackage

// File: rtl/mixer_scheduler_arbiter.sv
// Round-robin search over a request vector with a registered last-grant pointer.
// Until the first grant after reset the search starts at channel 0 itself rather than pointer+1.
module round_robin_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              ipClk,
    input  logic              ipReset,
    input  logic [NUM_CH-1:0] ipRequest,
    input  logic              ipEnable,
    output logic              opGrantValid,
    output logic [CH_W-1:0]   opGrantIdx
);

    logic [CH_W-1:0] pointer_reg;
    logic            primed_reg;
    logic            found;

    // Walk the order backwards so the last hit written is the highest-priority one.
    always_comb begin
        int idx;
        idx          = 0;
        found        = 1'b0;
        opGrantIdx   = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            idx = (int'(pointer_reg) + (primed_reg ? 1 : 0) + j) % NUM_CH;
            if (ipRequest[idx]) begin
                found      = 1'b1;
                opGrantIdx = CH_W'(idx);
            end
        end
        opGrantValid = found && ipEnable;
    end

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            pointer_reg <= '0;
            primed_reg  <= 1'b0;
        end else if (opGrantValid) begin
            pointer_reg <= opGrantIdx;
            primed_reg  <= 1'b1;
        end
    end

endmodule

// File: rtl/mixer_scheduler.sv
// Shares one registered 18x18 signed multiplier between NUM_CH real-input mixer channels.
// Optional build macro: MIXER_SCHEDULER_ROUNDING_EN (round half up in the output slice).
module mixer_scheduler
    import mixer_scheduler_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              ipClk,
    input  logic              ipReset,
    input  DATA_STREAM        ipInput [NUM_CH],
    input  COMPLEX_STREAM     ipNCO   [NUM_CH],
    input  logic              ipClearOverflow,
    output COMPLEX_STREAM     opOutput,
    output logic [CH_W-1:0]   opChannel,
    output logic [NUM_CH-1:0] opOverflow,
    output logic              opBusy
);

    MIXER_SCHED_STATE state_reg, state_next;

    logic                     grantEnable, grantFire;
    logic [CH_W-1:0]          grantIdx;
    logic                     captureI, emitResult, mulSelQ;

    logic [NUM_CH-1:0]        holdFullVec, request, drop;
    logic signed [DATA_W-1:0] holdDataVec [NUM_CH];
    logic signed [DATA_W-1:0] holdNcoIVec [NUM_CH];
    logic signed [DATA_W-1:0] holdNcoQVec [NUM_CH];
    logic [NUM_CH-1:0]        unusedNcoValid;

    logic signed [DATA_W-1:0] operData_reg, operNcoI_reg, operNcoQ_reg;
    logic [CH_W-1:0]          operChan_reg;
    logic signed [DATA_W-1:0] selData, selNcoI, selNcoQ, mulB;
    logic signed [35:0]       productFull;
    logic [PROD_W-1:0]        product, productI_reg;
    logic [1:0]               unusedProductMsb;

    COMPLEX_STREAM            outData_reg;
    logic [CH_W-1:0]          outChannel_reg;
    logic [NUM_CH-1:0]        overflow_reg;

    // Per-channel 1-deep holding registers. A sample arriving on an empty, granted channel
    // bypasses the hold and goes straight to the operand registers.
    genvar gi;
    for (gi = 0; gi < NUM_CH; gi++) begin : g_hold
        logic                     holdFull_reg;
        logic signed [DATA_W-1:0] holdData_reg, holdNcoI_reg, holdNcoQ_reg;
        logic                     inValid, isGranted, loadHold;

        assign inValid   = ipInput[gi].Valid;
        assign isGranted = grantFire && (grantIdx == CH_W'(gi));
        assign loadHold  = inValid && (holdFull_reg ? isGranted : !isGranted);

        assign request[gi]        = holdFull_reg | inValid;
        assign drop[gi]           = inValid & holdFull_reg & ~isGranted;
        assign holdFullVec[gi]    = holdFull_reg;
        assign holdDataVec[gi]    = holdData_reg;
        assign holdNcoIVec[gi]    = holdNcoI_reg;
        assign holdNcoQVec[gi]    = holdNcoQ_reg;
        assign unusedNcoValid[gi] = ipNCO[gi].Valid;

        always_ff @(posedge ipClk) begin
            if (ipReset) begin
                holdFull_reg <= 1'b0;
                holdData_reg <= '0;
                holdNcoI_reg <= '0;
                holdNcoQ_reg <= '0;
            end else if (loadHold) begin
                holdFull_reg <= 1'b1;
                holdData_reg <= ipInput[gi].Data;
                holdNcoI_reg <= ipNCO[gi].I;
                holdNcoQ_reg <= ipNCO[gi].Q;
            end else if (isGranted) begin
                holdFull_reg <= 1'b0;
            end
        end
    end

    round_robin_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arbiter (
        .ipClk        (ipClk),
        .ipReset      (ipReset),
        .ipRequest    (request),
        .ipEnable     (grantEnable),
        .opGrantValid (grantFire),
        .opGrantIdx   (grantIdx)
    );

    always_ff @(posedge ipClk) begin
        if (ipReset) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grantFire) state_next = MUL_I;
            MUL_I:   state_next = MUL_Q;
            MUL_Q:   state_next = grantFire ? MUL_I : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grantEnable = 1'b0;
        captureI    = 1'b0;
        emitResult  = 1'b0;
        mulSelQ     = 1'b0;
        opBusy      = (state_reg != IDLE);
        case (state_reg)
            IDLE:  grantEnable = 1'b1;
            MUL_I: captureI    = 1'b1;
            MUL_Q: begin
                grantEnable = 1'b1;
                emitResult  = 1'b1;
                mulSelQ     = 1'b1;
            end
            default: ;
        endcase
    end

    assign selData = holdFullVec[grantIdx] ? holdDataVec[grantIdx] : ipInput[grantIdx].Data;
    assign selNcoI = holdFullVec[grantIdx] ? holdNcoIVec[grantIdx] : ipNCO[grantIdx].I;
    assign selNcoQ = holdFullVec[grantIdx] ? holdNcoQVec[grantIdx] : ipNCO[grantIdx].Q;

    // The I product is registered in MUL_I; the Q product is registered straight into the output.
    assign mulB             = mulSelQ ? operNcoQ_reg : operNcoI_reg;
    assign productFull      = operData_reg * mulB;
    assign product          = productFull[PROD_W-1:0];
    assign unusedProductMsb = productFull[35:34];

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            operData_reg   <= '0;
            operNcoI_reg   <= '0;
            operNcoQ_reg   <= '0;
            operChan_reg   <= '0;
            productI_reg   <= '0;
            outData_reg    <= '0;
            outChannel_reg <= '0;
        end else begin
            if (grantFire) begin
                operData_reg <= selData;
                operNcoI_reg <= selNcoI;
                operNcoQ_reg <= selNcoQ;
                operChan_reg <= grantIdx;
            end
            if (captureI) productI_reg <= product;
            outData_reg.Valid <= emitResult;
            if (emitResult) begin
                outData_reg.I  <= mixSlice(productI_reg);
                outData_reg.Q  <= mixSlice(product);
                outChannel_reg <= operChan_reg;
            end
        end
    end

    // A drop in the same cycle as a clear keeps its flag.
    always_ff @(posedge ipClk) begin
        if (ipReset) overflow_reg <= '0;
        else         overflow_reg <= (ipClearOverflow ? '0 : overflow_reg) | drop;
    end

    assign opOutput   = outData_reg;
    assign opChannel  = outChannel_reg;
    assign opOverflow = overflow_reg;

endmodule

// File: doc/mixer_scheduler.md
Name: mixer_scheduler

Overview:
- Time-shares one registered 18x18 signed multiplier between NUM_CH real-input mixing channels.
- Each channel has its own data stream and its own NCO stream.
- Each accepted sample takes two multiplier cycles: I product, then Q product.
- Sits between the per-channel ADC/decimator streams and the downstream per-channel filters. It replaces NUM_CH parallel mixer instances when the aggregate sample rate is at most one sample per 2 clocks.

Parameters:
- NUM_CH, 4: number of input channels, range 2..16.
- CH_W, $clog2(NUM_CH): width of the channel tag. Derived, not overridable.

Ports:
- ipClk  input  1  system clock.
- ipReset  input  1  synchronous, active-high reset.
- ipInput  input  DATA_STREAM[NUM_CH]  per-channel sample stream. Data is 18-bit signed. Valid is a single-cycle strobe. There is no backpressure.
- ipNCO  input  COMPLEX_STREAM[NUM_CH]  per-channel NCO. I and Q are 18-bit signed. Valid is always high and is ignored.
- ipClearOverflow  input  1  single-cycle strobe; clears all overflow flags.
- opOutput  output  COMPLEX_STREAM  mixed result. I and Q are 18-bit signed. Valid is a single-cycle strobe.
- opChannel  output  CH_W  channel tag of opOutput; meaningful only while opOutput.Valid is high.
- opOverflow  output  NUM_CH  sticky per-channel flag: a sample was dropped.
- opBusy  output  1  high while the state is not IDLE.

Behaviour:
- Reset: all holding registers empty, state IDLE, round-robin pointer = channel 0. opOutput.I, opOutput.Q, opOutput.Valid, opChannel, opOverflow and opBusy are all 0.
- Capture: each channel has a 1-deep holding register storing Data plus the NCO I and Q values sampled in the same cycle.
  - ipInput[c].Valid with hold[c] empty: load hold[c] and set it full.
  - ipInput[c].Valid with hold[c] full and not being granted this cycle: drop the sample and set opOverflow[c]. The held sample is kept.
  - Valid in the same cycle that hold[c] is granted: load it; no overflow.
- Arbitration: round-robin over full holds, searching from pointer+1 (wrapping) back to the pointer.
  - Evaluated in IDLE and in MUL_Q.
  - On grant, the held sample moves to the operand registers, hold[c] is emptied and the pointer is set to c.
- State machine:
  - IDLE: go to MUL_I on a grant, else stay in IDLE.
  - MUL_I: multiply operand Data x NCO.I. Always go to MUL_Q next.
  - MUL_Q: multiply operand Data x NCO.Q and latch the I result. On a grant go to MUL_I (back-to-back operation), else go to IDLE.
- Arithmetic:
  - 34-bit signed product; result = product[32:15].
  - Truncation toward negative infinity.
  - No saturation; the -131072 x -131072 corner wraps.
- Output:
  - opOutput.I, opOutput.Q and opChannel are registered and updated together, with Valid high for 1 cycle.
  - They hold their values until the next result.
- Latency: input Valid in cycle 0 with no contention gives opOutput.Valid in cycle 3.
- Throughput: 1 result per 2 cycles aggregate.
- Overflow flags:
  - ipClearOverflow clears all flags.
  - A drop in the same cycle as a clear leaves that flag set (set wins).
- Reset mid-operation: the in-flight sample and all held samples are discarded. No output Valid is asserted afterwards for them.

Optional Feature:
- Macro: MIXER_SCHEDULER_ROUNDING_EN.
- Defined: add 2^14 to the 34-bit product before slicing [32:15] (round half up). There is still no saturation. Latency is unchanged.
- Undefined: plain truncation as above.

Decomposition:
- Structures package:
  - reuse DATA_STREAM and COMPLEX_STREAM;
  - add MIXER_SCHED_STATE enum (IDLE, MUL_I, MUL_Q);
  - add constant MIXER_SHIFT = 15.
- Sub-module: round_robin_arbiter. Parameterised by NUM_CH. Inputs: request vector, pointer, enable. Outputs: grant-valid and grant index. Purely combinational search plus registered pointer.

Test Plan:
- Single sample: ch0 Data=32768, NCO I=65536, Q=-65536 at cycle 0 -> cycle 3: Valid=1, I=65536, Q=-65536, opChannel=0. opBusy high in cycles 1-2.
- Contention: ch0..ch3 Valid together at cycle 0 -> results for channels 0, 1, 2, 3 at cycles 3, 5, 7, 9. opBusy stays high, with no IDLE gap.
- Overflow: ch0 and ch1 Valid at cycle 0, ch1 Valid again at cycle 1 -> opOverflow=0b0010. The first ch1 sample is output at cycle 5 and the second is dropped. ipClearOverflow then returns opOverflow to 0.
- Refill on grant: ch1 Valid in the cycle its hold is granted -> no overflow, and both samples are output.
- Rounding: Data=1, NCO I=16384 -> I=0 without the macro, I=1 with MIXER_SCHEDULER_ROUNDING_EN. Data=-1, I=16384 -> -1 without, 0 with.
- Reset mid-operation: ipReset asserted during MUL_I with 2 holds full -> next cycle all outputs are 0 and the state is IDLE. No Valid appears for the discarded samples; the pointer is back at 0.
